// File: rtl/serial2parallel_if.sv
// rtl/serial2parallel_if.sv - framed serial input and parallel valid/ready output bundle
interface serial2parallel_if #(
    parameter int WIDTH = 8
);
    logic             sin_d;
    logic             sin_start;
    logic             sin_end;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    modport master (
        output sin_d, sin_start, sin_end, dout_ready,
        input  dout, dout_valid, busy, frame_err, overrun
    );

    modport slave (
        input  sin_d, sin_start, sin_end, dout_ready,
        output dout, dout_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/serial2parallel.sv
// rtl/serial2parallel.sv - LSB-first framed serial-to-parallel receiver with output register
module serial2parallel #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    serial2parallel_if.slave s2p
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam int IW = $clog2(WIDTH);

    typedef enum logic {IDLE, RECV} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] dout_r, dout_n;
    logic             valid_r, valid_n;
    logic             ferr_r, ferr_n;
    logic             ovr_r, ovr_n;
    logic             done;
    logic             out_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            dout_r  <= '0;
            valid_r <= 1'b0;
            ferr_r  <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shreg   <= shreg_n;
            dout_r  <= dout_n;
            valid_r <= valid_n;
            ferr_r  <= ferr_n;
            ovr_r   <= ovr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        ferr_n  = 1'b0;
        done    = 1'b0;
        word    = shreg;
        word[WIDTH-1] = s2p.sin_d;

        case (state)
            IDLE: begin
                if (s2p.sin_end) begin
                    ferr_n = 1'b1;
                end else if (s2p.sin_start) begin
                    shreg_n    = '0;
                    shreg_n[0] = s2p.sin_d;
                    cnt_n      = CW'(1);
                    state_n    = RECV;
                end
            end
            RECV: begin
                if (s2p.sin_start) begin
                    // Abort: a fresh start bit always wins over the frame in flight
                    ferr_n  = 1'b1;
                    shreg_n = '0;
                    if (s2p.sin_end) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        shreg_n[0] = s2p.sin_d;
                        cnt_n      = CW'(1);
                    end
                end else if (cnt == CW'(WIDTH - 1)) begin
                    if (s2p.sin_end) begin
                        done = 1'b1;
                    end else begin
                        ferr_n = 1'b1;
                    end
                    shreg_n = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (s2p.sin_end) begin
                    ferr_n  = 1'b1;
                    shreg_n = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    shreg_n[cnt[IW-1:0]] = s2p.sin_d;
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                shreg_n = '0;
            end
        endcase
    end

    // Output register is free when empty or being drained on this same edge
    always_comb begin
        out_free = !valid_r || s2p.dout_ready;
        dout_n   = dout_r;
        valid_n  = valid_r && !s2p.dout_ready;
        ovr_n    = 1'b0;
        if (done) begin
            if (out_free) begin
                dout_n  = word;
                valid_n = 1'b1;
            end else begin
                ovr_n = 1'b1;
            end
        end
    end

    assign s2p.dout       = dout_r;
    assign s2p.dout_valid = valid_r;
    assign s2p.busy       = (state == RECV);
    assign s2p.frame_err  = ferr_r;
    assign s2p.overrun    = ovr_r;
endmodule

// File: tb/tb_serial2parallel.sv
// tb/tb_serial2parallel.sv - directed and randomized check of serial2parallel against a queue model
module tb_serial2parallel;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial2parallel_if #(.WIDTH(W)) bus ();
    serial2parallel #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .s2p(bus));

    int n_cmp = 0;
    int n_bad = 0;

    // Model: received bits of the current frame and the expected registered outputs
    bit       q[$];
    bit       m_active = 0;
    bit [W-1:0] m_dout = '0;
    bit       m_valid = 0;
    bit       m_ferr = 0;
    bit       m_ovr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("dout", 32'(bus.dout), 32'(m_dout));
        chk("dout_valid", 32'(bus.dout_valid), 32'(m_valid));
        chk("busy", 32'(bus.busy), 32'(m_active));
        chk("frame_err", 32'(bus.frame_err), 32'(m_ferr));
        chk("overrun", 32'(bus.overrun), 32'(m_ovr));
    endtask

    task automatic model_step(input bit d, input bit s, input bit e, input bit r);
        bit done = 0;
        bit free;
        int w = 0;
        m_ferr = 0;
        m_ovr  = 0;
        if (!m_active) begin
            if (e) m_ferr = 1;
            else if (s) begin
                q.delete();
                q.push_back(d);
                m_active = 1;
            end
        end else if (s) begin
            m_ferr = 1;
            q.delete();
            if (e) m_active = 0;
            else q.push_back(d);
        end else begin
            q.push_back(d);
            if (e || q.size() == W) begin
                if (e && q.size() == W) done = 1;
                else m_ferr = 1;
                m_active = 0;
            end
        end
        foreach (q[i]) w += int'(q[i]) << i;
        free = !m_valid || r;
        if (m_valid && r) m_valid = 0;
        if (done) begin
            if (free) begin
                m_dout  = W'(w);
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end
    endtask

    task automatic tick(input bit d, input bit s, input bit e, input bit r);
        @(negedge clk);
        compare_all();
        bus.sin_d      = d;
        bus.sin_start  = s;
        bus.sin_end    = e;
        bus.dout_ready = r;
        model_step(d, s, e, r);
    endtask

    // rmode: 0 ready low, 1 ready high, 2 random, 3 ready only on the last bit
    task automatic frame(input logic [7:0] w, input int nbits, input bit with_end, input int rmode);
        bit r;
        for (int k = 0; k < nbits; k++) begin
            case (rmode)
                0: r = 0;
                1: r = 1;
                2: r = 1'($urandom_range(0, 1));
                default: r = (k == nbits - 1);
            endcase
            tick(w[k], k == 0, with_end && (k == nbits - 1), r);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.sin_d = 0; bus.sin_start = 0; bus.sin_end = 0; bus.dout_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(bus.dout), 0);
        chk("rst_valid", 32'(bus.dout_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;

        // Basic frame
        frame(8'hA5, 8, 1, 1);
        tick(0, 0, 0, 1);
        chk("basic_dout", 32'(bus.dout), 32'hA5);
        chk("basic_valid", 32'(bus.dout_valid), 1);

        // Back-to-back with backpressure
        frame(8'h3C, 8, 1, 0);
        frame(8'hFF, 8, 1, 0);
        tick(0, 0, 0, 0);
        chk("bp_overrun", 32'(bus.overrun), 1);
        chk("bp_dout", 32'(bus.dout), 32'h3C);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        chk("bp_drained", 32'(bus.dout_valid), 0);

        // Simultaneous release
        frame(8'h11, 8, 1, 0);
        frame(8'h22, 8, 1, 3);
        tick(0, 0, 0, 0);
        chk("sim_dout", 32'(bus.dout), 32'h22);
        chk("sim_valid", 32'(bus.dout_valid), 1);
        chk("sim_overrun", 32'(bus.overrun), 0);
        tick(0, 0, 0, 1);

        // Premature end
        frame(8'h77, 5, 1, 1);
        tick(0, 0, 0, 1);
        chk("pre_ferr", 32'(bus.frame_err), 1);
        chk("pre_busy", 32'(bus.busy), 0);
        frame(8'h5A, 8, 1, 1);
        tick(0, 0, 0, 1);
        chk("pre_next", 32'(bus.dout), 32'h5A);

        // Missing end, then abort-restart
        frame(8'hAB, 8, 0, 1);
        tick(0, 0, 0, 1);
        chk("miss_ferr", 32'(bus.frame_err), 1);
        frame(8'hE7, 3, 0, 1);
        frame(8'hC3, 8, 1, 1);
        tick(0, 0, 0, 1);
        chk("restart_dout", 32'(bus.dout), 32'hC3);

        // Reset mid-frame
        frame(8'h99, 5, 0, 1);
        @(negedge clk);
        rst_n = 1'b0;
        bus.sin_d = 0; bus.sin_start = 0; bus.sin_end = 0; bus.dout_ready = 0;
        #1;
        chk("mid_rst_dout", 32'(bus.dout), 0);
        chk("mid_rst_valid", 32'(bus.dout_valid), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        q.delete();
        m_active = 0; m_dout = '0; m_valid = 0; m_ferr = 0; m_ovr = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(0, 0, 1, 1);
        tick(0, 0, 0, 1);
        chk("stray_end", 32'(bus.frame_err), 1);
        frame(8'h0F, 8, 1, 1);
        tick(0, 0, 0, 1);
        chk("post_rst", 32'(bus.dout), 32'h0F);

        // Randomized frames with occasional framing faults and random backpressure
        for (int f = 0; f < 300; f++) begin
            int gap   = $urandom_range(0, 2);
            int ftype = $urandom_range(0, 9);
            logic [7:0] w = 8'($urandom);
            for (int g = 0; g < gap; g++)
                tick(1'($urandom), 0, ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
            case (ftype)
                7: frame(w, $urandom_range(1, W - 1), 1, 2);
                8: frame(w, W, 0, 2);
                9: begin
                    frame(w, $urandom_range(1, W - 1), 0, 2);
                    frame(8'($urandom), W, 1, 2);
                end
                default: frame(w, W, 1, 2);
            endcase
        end
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
